// File: rtl/bsg_cover_arb_pkg.sv
// bsg_cover_arb_pkg: shared state encoding for the coverage drain arbiter
package bsg_cover_arb_pkg;
  typedef enum logic [2:0] {IDLE, GRANT, FL_PULSE, FL_WAIT, FL_GRANT} bsg_cover_arb_state_e;
endpackage

// File: rtl/bsg_cover_rr_pick.sv
// bsg_cover_rr_pick: first set request at or after ptr, wrapping around
module bsg_cover_rr_pick
  import bsg_cover_arb_pkg::*;
#(
  parameter int num_p = 4,
  parameter int lg_p  = (num_p > 1) ? $clog2(num_p) : 1
) (
  input  logic [num_p-1:0] req,
  input  logic [lg_p-1:0]  ptr,
  output logic [lg_p-1:0]  idx,
  output logic             v
);
  logic [lg_p-1:0] j;
  // scan from farthest to nearest so the closest request after ptr wins
  always_comb begin
    idx = '0;
    j   = '0;
    v   = |req;
    for (int i = num_p - 1; i >= 0; i--) begin
      j = lg_p'((int'(ptr) + i) % num_p);
      if (req[j]) idx = j;
    end
  end
endmodule

// File: rtl/bsg_cover_drain_arbiter.sv
// bsg_cover_drain_arbiter: round-robin owner of the coverage stream with a host flush walk
module bsg_cover_drain_arbiter
  import bsg_cover_arb_pkg::*;
#(
  parameter  int num_covers_p = 4,
  parameter  int width_p      = 64,
  localparam int lg_covers_lp = (num_covers_p > 1) ? $clog2(num_covers_p) : 1
) (
  input  logic                            ds_clk_i,
  input  logic                            ds_reset_n_i,
  input  logic [num_covers_p-1:0]         cov_gate_i,
  input  logic [num_covers_p-1:0]         cov_v_i,
  input  logic [num_covers_p-1:0]         cov_idx_v_i,
  input  logic [num_covers_p*width_p-1:0] cov_data_i,
  output logic [num_covers_p-1:0]         cov_ready_o,
  output logic [num_covers_p-1:0]         cov_drain_o,
  input  logic                            drain_req_i,
  output logic                            drain_done_o,
  output logic                            busy_o,
  output logic [lg_covers_lp-1:0]         grant_o,
  output logic                            v_o,
  output logic                            idx_v_o,
  output logic [width_p-1:0]              data_o,
  input  logic                            ready_i
);
  localparam logic [lg_covers_lp-1:0] last_lp = lg_covers_lp'(num_covers_p - 1);
  bsg_cover_arb_state_e state_r, state_n;
  logic [lg_covers_lp-1:0] grant_r, grant_n, rr_ptr_r, rr_ptr_n, fl_ptr_r, fl_ptr_n, pick_idx;
  logic flush_pend_r, flush_pend_n, pick_v, routed, in_flush;

  function automatic logic [lg_covers_lp-1:0] wrap_inc(input logic [lg_covers_lp-1:0] p);
    return (p == last_lp) ? '0 : p + 1'b1;
  endfunction

  bsg_cover_rr_pick #(.num_p(num_covers_p), .lg_p(lg_covers_lp)) pick (
    .req(cov_gate_i),
    .ptr(rr_ptr_r),
    .idx(pick_idx),
    .v  (pick_v)
  );

  assign routed       = (state_r == GRANT) || (state_r == FL_GRANT);
  assign in_flush     = (state_r == FL_PULSE) || (state_r == FL_WAIT) || (state_r == FL_GRANT);
  assign v_o          = routed & cov_v_i[grant_r];
  assign idx_v_o      = routed & cov_idx_v_i[grant_r];
  assign data_o       = routed ? cov_data_i[grant_r*width_p +: width_p] : '0;
  assign cov_ready_o  = (routed && ready_i) ? num_covers_p'(1) << grant_r : '0;
  assign busy_o       = (state_r != IDLE) || flush_pend_r;
  assign grant_o      = grant_r;

  // next-state, pointer updates, drain pulses and flush bookkeeping
  always_comb begin
    state_n      = state_r;
    grant_n      = grant_r;
    rr_ptr_n     = rr_ptr_r;
    fl_ptr_n     = fl_ptr_r;
    flush_pend_n = flush_pend_r;
    cov_drain_o  = '0;
    drain_done_o = 1'b0;
    case (state_r)
      IDLE:
        if (flush_pend_r) begin
          state_n      = FL_PULSE;
          fl_ptr_n     = '0;
          flush_pend_n = 1'b0;
        end else if (pick_v) begin
          state_n = GRANT;
          grant_n = pick_idx;
        end
      GRANT:
        if (!cov_gate_i[grant_r]) begin
          state_n  = IDLE;
          rr_ptr_n = wrap_inc(grant_r);
        end
      FL_PULSE: begin
        cov_drain_o[fl_ptr_r] = 1'b1;
        state_n               = FL_WAIT;
      end
      FL_WAIT:
        if (cov_gate_i[fl_ptr_r]) begin
          grant_n = fl_ptr_r;
          state_n = FL_GRANT;
        end
      FL_GRANT:
        if (!cov_gate_i[grant_r]) begin
          fl_ptr_n     = wrap_inc(fl_ptr_r);
          drain_done_o = (fl_ptr_r == last_lp);
          state_n      = (fl_ptr_r == last_lp) ? IDLE : FL_PULSE;
        end
      default: state_n = IDLE;
    endcase
    if (drain_req_i && !in_flush && !flush_pend_r) flush_pend_n = 1'b1;
  end

  // state and pointer registers
  always_ff @(posedge ds_clk_i or negedge ds_reset_n_i) begin
    if (!ds_reset_n_i) begin
      state_r      <= IDLE;
      grant_r      <= '0;
      rr_ptr_r     <= '0;
      fl_ptr_r     <= '0;
      flush_pend_r <= 1'b0;
    end else begin
      state_r      <= state_n;
      grant_r      <= grant_n;
      rr_ptr_r     <= rr_ptr_n;
      fl_ptr_r     <= fl_ptr_n;
      flush_pend_r <= flush_pend_n;
    end
  end
endmodule

// File: tb/tb_bsg_cover_drain_arbiter.sv
// tb_bsg_cover_drain_arbiter: scoreboard bench with behavioural collectors
module tb_bsg_cover_drain_arbiter;
  localparam int N = 4;
  localparam int W = 64;
  logic ds_clk_i = 1'b0;
  logic ds_reset_n_i = 1'b0;
  logic [N-1:0] gate, vv, idxv, cov_ready_o, cov_drain_o;
  logic [N*W-1:0] data;
  logic drain_req_i = 1'b0;
  logic drain_done_o, busy_o, v_o, idx_v_o;
  logic ready_i = 1'b1;
  logic [1:0] grant_o;
  logic [W-1:0] data_o;
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int d0;
  int cnt[N];
  int sent[N];
  int dcnt[N] = '{2, 1, 3, 1};
  logic [W:0] exp_q[$];
  logic [N-1:0] drn_q[$];

  bsg_cover_drain_arbiter #(.num_covers_p(N), .width_p(W)) dut (
    .ds_clk_i(ds_clk_i), .ds_reset_n_i(ds_reset_n_i),
    .cov_gate_i(gate), .cov_v_i(vv), .cov_idx_v_i(idxv), .cov_data_i(data),
    .cov_ready_o(cov_ready_o), .cov_drain_o(cov_drain_o),
    .drain_req_i(drain_req_i), .drain_done_o(drain_done_o), .busy_o(busy_o),
    .grant_o(grant_o), .v_o(v_o), .idx_v_o(idx_v_o), .data_o(data_o), .ready_i(ready_i)
  );

  always #5 ds_clk_i = ~ds_clk_i;

  function automatic logic [W-1:0] mk(input int i, input int k);
    return 64'hC0DE_0000_0000_0000 | (64'(i) << 8) | 64'(k);
  endfunction

  task automatic chk(input string nm, input logic [W:0] act, input logic [W:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < N; i++) begin
      vv[i] = gate[i] && (sent[i] < cnt[i]);
      idxv[i] = gate[i] && (sent[i] == 0);
      data[i*W +: W] = gate[i] ? mk(i, sent[i]) : '0;
    end
  endtask

  task automatic start(input int i, input int n);
    cnt[i] = n;
    sent[i] = 0;
    gate[i] = 1'b1;
    refresh();
  endtask

  task automatic push_beats(input int i, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back({k == 0, mk(i, k)});
  endtask

  task automatic push_walk();
    for (int i = 0; i < N; i++) begin
      drn_q.push_back(N'(1) << i);
      push_beats(i, dcnt[i]);
    end
  endtask

  task automatic sync();
    @(posedge ds_clk_i);
    #2;
  endtask

  task automatic pulse_drain();
    drain_req_i = 1'b1;
    sync();
    drain_req_i = 1'b0;
  endtask

  task automatic wait_grant(input int g);
    bit found = 0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge ds_clk_i);
      found = v_o && (grant_o == 2'(g));
    end
    if (!found) chk("wait_grant_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit found = 0;
    for (int c = 0; c < 400 && !found; c++) begin
      @(negedge ds_clk_i);
      found = !busy_o && gate == '0 && exp_q.size() == 0 && drn_q.size() == 0;
    end
    if (!found) chk("wait_idle_timeout", 0, 1);
  endtask

  // collectors: consume beats on ready, drop gate after last beat, answer drain pulses
  initial begin : collectors
    logic [N-1:0] f, d;
    forever begin
      @(negedge ds_clk_i);
      f = cov_ready_o & vv;
      d = cov_drain_o;
      @(posedge ds_clk_i);
      #1;
      for (int i = 0; i < N; i++) begin
        if (!ds_reset_n_i) begin
          gate[i] = 1'b0;
          sent[i] = 0;
          cnt[i] = 0;
        end else begin
          if (f[i]) begin
            sent[i]++;
            if (sent[i] == cnt[i]) gate[i] = 1'b0;
          end
          if (d[i]) begin
            gate[i] = 1'b1;
            sent[i] = 0;
            cnt[i] = dcnt[i];
          end
        end
      end
      refresh();
    end
  end

  // scoreboard monitor
  initial begin : monitor
    logic [W:0] e;
    logic [N-1:0] de;
    forever begin
      @(negedge ds_clk_i);
      if (ds_reset_n_i) begin
        if (v_o && ready_i) begin
          if (exp_q.size() == 0) chk("beat_unexpected", {idx_v_o, data_o}, '0);
          else begin
            e = exp_q.pop_front();
            chk("beat", {idx_v_o, data_o}, e);
          end
        end
        if (cov_drain_o != '0) begin
          if (drn_q.size() == 0) chk("drain_unexpected", W'(cov_drain_o), '0);
          else begin
            de = drn_q.pop_front();
            chk("drain", W'(cov_drain_o), W'(de));
          end
        end
        if (drain_done_o) done_cnt++;
      end
    end
  end

  initial begin
    gate = '0;
    for (int i = 0; i < N; i++) begin
      cnt[i] = 0;
      sent[i] = 0;
    end
    refresh();
    repeat (3) @(negedge ds_clk_i);
    chk("rst_v", v_o, 0);
    chk("rst_idx", idx_v_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_ready", cov_ready_o, 0);
    chk("rst_drain", cov_drain_o, 0);
    chk("rst_done", drain_done_o, 0);
    chk("rst_busy", busy_o, 0);
    sync();
    ds_reset_n_i = 1'b1;
    repeat (3) @(negedge ds_clk_i);
    chk("idle_busy", busy_o, 0);
    chk("idle_v", v_o, 0);
    sync();
    push_beats(1, 4);
    push_beats(3, 2);
    start(1, 4);
    start(3, 2);
    wait_idle();
    sync();
    push_beats(0, 2);
    push_beats(2, 2);
    start(0, 2);
    start(2, 2);
    wait_idle();
    sync();
    push_beats(3, 1);
    push_beats(2, 6);
    start(2, 6);
    start(3, 1);
    wait_grant(2);
    sync();
    ready_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge ds_clk_i);
      chk("stall_v", v_o, 1);
      chk("stall_data", data_o, exp_q[0][W-1:0]);
      chk("stall_ready", cov_ready_o, 0);
    end
    sync();
    ready_i = 1'b1;
    wait_idle();
    sync();
    d0 = done_cnt;
    push_walk();
    pulse_drain();
    wait_idle();
    chk("walk_done", done_cnt - d0, 1);
    sync();
    d0 = done_cnt;
    push_beats(2, 4);
    push_walk();
    start(2, 4);
    wait_grant(2);
    sync();
    pulse_drain();
    wait_grant(1);
    sync();
    pulse_drain();
    wait_idle();
    chk("grant_walk_done", done_cnt - d0, 1);
    repeat (6) @(negedge ds_clk_i);
    chk("no_second_flush", busy_o, 0);
    chk("no_second_done", done_cnt - d0, 1);
    sync();
    ready_i = 1'b0;
    drn_q.push_back(N'(1));
    pulse_drain();
    wait_grant(0);
    #1 ds_reset_n_i = 1'b0;
    #1;
    chk("arst_v", v_o, 0);
    chk("arst_idx", idx_v_o, 0);
    chk("arst_data", data_o, 0);
    chk("arst_ready", cov_ready_o, 0);
    chk("arst_drain", cov_drain_o, 0);
    chk("arst_busy", busy_o, 0);
    sync();
    sync();
    ds_reset_n_i = 1'b1;
    ready_i = 1'b1;
    repeat (6) @(negedge ds_clk_i);
    chk("post_rst_busy", busy_o, 0);
    chk("post_rst_grant", grant_o, 0);
    chk("post_rst_drain", cov_drain_o, 0);
    chk("beats_left", exp_q.size(), 0);
    chk("drains_left", drn_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
